// File: rtl/fifo_rd_ptr_empty.sv
// rtl/fifo_rd_ptr_empty.sv - read-side pointer, empty flag and fill level for the async FIFO
module fifo_rd_ptr_empty #(
  parameter  int ADDR_W = 3,
  localparam int PTR_W  = ADDR_W + 1
) (
  input  logic              r_clk,
  input  logic              r_rst_n,
  input  logic              r_inc,
  input  logic [PTR_W-1:0]  w_ptr,
  output logic [ADDR_W-1:0] r_addr,
  output logic [PTR_W-1:0]  r_ptr,
  output logic              r_empty,
  output logic [PTR_W-1:0]  r_level
);

  logic [PTR_W-1:0] rq1_wptr;
  logic [PTR_W-1:0] rq2_wptr;
  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_bin_next;
  logic [PTR_W-1:0] r_gray_next;
  logic [PTR_W-1:0] rq2_wbin;
  logic             pop;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-pointer arithmetic; a request is honoured only while data is visible
  always_comb begin
    pop         = r_inc & ~r_empty;
    r_bin_next  = r_bin + {{(PTR_W-1){1'b0}}, pop};
    r_gray_next = r_bin_next ^ (r_bin_next >> 1);
    rq2_wbin    = gray2bin(rq2_wptr);
    r_level     = rq2_wbin - r_bin;
  end

  // Two-flop synchroniser bringing the write Gray pointer into the read domain
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rq1_wptr <= '0;
      rq2_wptr <= '0;
    end else begin
      rq1_wptr <= w_ptr;
      rq2_wptr <= rq1_wptr;
    end
  end

  // Read pointer registers and empty flag; empty is judged on the post-pop pointer
  // so draining the last entry raises it at the same edge
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_bin   <= '0;
      r_ptr   <= '0;
      r_empty <= 1'b1;
    end else begin
      r_bin   <= r_bin_next;
      r_ptr   <= r_gray_next;
      r_empty <= (r_gray_next == rq2_wptr);
    end
  end

  assign r_addr = r_bin[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// tb/tb_fifo_rd_ptr_empty.sv - randomized model-checked bench for fifo_rd_ptr_empty
module tb_fifo_rd_ptr_empty;

  logic       r_clk;
  logic       r_rst_n;
  logic       r_inc;
  logic [3:0] w_ptr;
  logic [2:0] r_addr;
  logic [3:0] r_ptr;
  logic       r_empty;
  logic [3:0] r_level;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state, all plain counts modulo 16
  int  wcnt;
  int  rcnt;
  int  s1;
  int  s2;
  bit  m_empty;
  bit  chk_en = 0;
  int  wraps;

  fifo_rd_ptr_empty #(.ADDR_W(3)) dut (
    .r_clk   (r_clk),
    .r_rst_n (r_rst_n),
    .r_inc   (r_inc),
    .w_ptr   (w_ptr),
    .r_addr  (r_addr),
    .r_ptr   (r_ptr),
    .r_empty (r_empty),
    .r_level (r_level)
  );

  initial r_clk = 0;
  always #5 r_clk = ~r_clk;

  function automatic int gray(input int v);
    return (v ^ (v >> 1)) & 15;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wcnt    = 0;
    rcnt    = 0;
    s1      = 0;
    s2      = 0;
    m_empty = 1;
  endtask

  // one read clock of the model: the pop sees the write count from two clocks ago
  task automatic model_step();
    int pop;
    int nr;
    pop = (r_inc && !m_empty) ? 1 : 0;
    nr  = (rcnt + pop) & 15;
    if (pop == 1 && nr == 0) wraps++;
    m_empty = (nr == s2);
    s2   = s1;
    s1   = wcnt;
    rcnt = nr;
  endtask

  // inputs are set at a falling edge; this advances one rising edge and returns at the next falling edge
  task automatic tick();
    w_ptr = 4'(gray(wcnt));
    @(posedge r_clk);
    model_step();
    @(negedge r_clk);
  endtask

  task automatic do_reset();
    #2 r_rst_n = 0;
    #1;
    check("rst_empty", r_empty, 1);
    check("rst_addr",  r_addr,  0);
    check("rst_ptr",   r_ptr,   0);
    check("rst_level", r_level, 0);
    model_reset();
    r_inc = 0;
    w_ptr = 0;
    @(negedge r_clk);
    r_rst_n = 1;
  endtask

  // continuous comparison of every output against the model
  always @(negedge r_clk) begin
    if (chk_en && r_rst_n) begin
      check("addr",  r_addr,  rcnt & 7);
      check("ptr",   r_ptr,   gray(rcnt));
      check("empty", r_empty, m_empty);
      check("level", r_level, (s2 - rcnt) & 15);
    end
  end

  initial begin
    logic [3:0] exp_ptr [4];
    exp_ptr = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    wraps   = 0;
    r_rst_n = 1;
    r_inc   = 0;
    w_ptr   = 0;
    model_reset();
    @(negedge r_clk);
    do_reset();
    chk_en = 1;
    repeat (3) tick();

    // write visibility latency
    wcnt = 1;
    tick();
    check("lat_n_empty", r_empty, 1);
    check("lat_n_level", r_level, 0);
    tick();
    check("lat_n1_empty", r_empty, 1);
    check("lat_n1_level", r_level, 1);
    tick();
    check("lat_n2_empty", r_empty, 0);

    // drain four entries with r_inc held
    do_reset();
    wcnt = 4;
    repeat (3) tick();
    check("drain_level", r_level, 4);
    check("drain_empty0", r_empty, 0);
    r_inc = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_addr", r_addr, i + 1);
      check("drain_ptr",  r_ptr,  exp_ptr[i]);
    end
    check("drain_empty1", r_empty, 1);

    // underflow attempts
    for (int i = 0; i < 5; i++) begin
      tick();
      check("uflow_addr",  r_addr,  4);
      check("uflow_ptr",   r_ptr,   4'b0110);
      check("uflow_level", r_level, 0);
    end

    // full read side
    r_inc = 0;
    do_reset();
    wcnt = 8;
    repeat (3) tick();
    check("full_level", r_level, 8);
    check("full_empty", r_empty, 0);
    r_inc = 1;
    repeat (8) tick();
    check("full_drained", r_empty, 1);
    check("full_ptr", r_ptr, 4'b1100);
    r_inc = 0;

    // random traffic across several pointer wraps, with a reset in the middle
    do_reset();
    wraps = 0;
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      r_inc = ($urandom_range(0, 99) < 50);
      if (((wcnt - rcnt) & 15) < 8 && $urandom_range(0, 99) < 55)
        wcnt = (wcnt + 1) & 15;
      tick();
    end
    n_tests++;
    if (wraps < 2) begin
      n_fail++;
      $display("FAIL wrap_seen: got %0d wraps expected at least 2", wraps);
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
